// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: active-low segment
// patterns (bit7 = dp, bits 6..0 = g..a) and the BCD converter state type.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hD8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational BCD-to-segment decoder (active-low g..a); dash wins over blank.
module seg7_digit_lut
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    if (dash) begin
      seg = SEG_DASH[6:0];
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0[6:0];
        4'd1:    seg = SEG_1[6:0];
        4'd2:    seg = SEG_2[6:0];
        4'd3:    seg = SEG_3[6:0];
        4'd4:    seg = SEG_4[6:0];
        4'd5:    seg = SEG_5[6:0];
        4'd6:    seg = SEG_6[6:0];
        4'd7:    seg = SEG_7[6:0];
        4'd8:    seg = SEG_8[6:0];
        4'd9:    seg = SEG_9[6:0];
        default: seg = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode display driver: sequential shift-and-add-3
// binary-to-BCD conversion feeding a continuously scanning digit multiplexer.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  num_in,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] digit_en
);

  localparam int         BCD_W = 4 * (DIGITS + 1);
  localparam int         CNT_W = $clog2(BIN_W + 1);
  localparam int         IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         DIV_W = $clog2(SCAN_DIV);
  localparam logic [63:0] LIMIT = pow10(DIGITS);

  state_t              state;
  logic [BIN_W-1:0]    shreg;
  logic [BCD_W-1:0]    bcd, bcd_adj, bcd_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic                big_in;
  logic [4*DIGITS-1:0] disp;
  logic [DIV_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [DIGITS-1:0]   blank_vec;
  logic                lz;
  logic [3:0]          cur_bcd;
  logic [6:0]          lut_seg;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, shreg} left.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], shreg[BIN_W-1]};
  end

  // The display register only changes on the final conversion step, so no
  // partially converted value ever reaches the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      shreg    <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      big_in   <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= num_in;
            bcd     <= '0;
            bit_cnt <= '0;
            big_in  <= (64'(num_in) >= LIMIT);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd     <= bcd_next;
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(BIN_W - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            disp     <= bcd_next[4*DIGITS-1:0];
            overflow <= big_in || (bcd_next[BCD_W-1 -: 4] != 4'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == DIV_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit above 0 is blank when it and every higher digit are zero.
  always_comb begin
    blank_vec = '0;
    lz        = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz           = lz && (disp[4*i +: 4] == 4'd0);
      blank_vec[i] = (BLANK_LZ != 0) && lz;
    end
  end

  assign cur_bcd = disp[4*int'(scan_idx) +: 4];

  seg7_digit_lut u_lut (
    .bcd   (cur_bcd),
    .blank (blank_vec[scan_idx]),
    .dash  (overflow),
    .seg   (lut_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg      <= SEG_BLANK;
      digit_en <= '1;
    end else begin
      seg      <= {~dp_mask[scan_idx], lut_seg};
      digit_en <= ~(DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: stimulus queues expected display
// values, a monitor checks each completed conversion over a full scan.
module tb_seg7_scan_display;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int WINDOW   = BIN_W + DIGITS * SCAN_DIV + 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load = 1'b0;
  logic [BIN_W-1:0]  num_in = '0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic              busy, overflow;
  logic [7:0]        seg;
  logic [DIGITS-1:0] digit_en;

  typedef struct {
    int                value;
    logic [DIGITS-1:0] dp;
    bit                aborted;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] seg_table [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  seg7_scan_display #(
    .DIGITS   (DIGITS),
    .BIN_W    (BIN_W),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .num_in   (num_in),
    .load     (load),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .digit_en (digit_en)
  );

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected pattern for digit idx of a decimal value, from the display rules.
  function automatic logic [7:0] exp_seg(input int value, input int idx,
                                         input logic [DIGITS-1:0] dp);
    logic [7:0] s;
    if (value >= pow10(DIGITS))             s = 8'hBF;
    else if (idx > 0 && value < pow10(idx)) s = 8'hFF;
    else                                    s = seg_table[(value / pow10(idx)) % 10];
    if (dp[idx]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Watch one full scan period, checking whichever digit is currently lit.
  task automatic check_scan(input int value, input logic [DIGITS-1:0] dp);
    logic [DIGITS-1:0] visited = '0;
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      int zeros = 0;
      int idx = 0;
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_en[i] !== 1'b1) begin
          zeros++;
          idx = i;
        end
      end
      checkOutput("digit_en single low", zeros, 1);
      if (zeros == 1) begin
        visited[idx] = 1'b1;
        checkOutput($sformatf("seg digit%0d value %0d", idx, value), seg,
                    exp_seg(value, idx, dp));
      end
      @(negedge clk);
    end
    checkOutput("all digits scanned", visited, {DIGITS{1'b1}});
  endtask

  task automatic applyStimulus(input int value, input logic [DIGITS-1:0] dp,
                               input bit aborted);
    exp_t e;
    e.value   = aborted ? 0 : value;
    e.dp      = dp;
    e.aborted = aborted;
    @(posedge clk); #1;
    num_in  = BIN_W'(value);
    dp_mask = dp;
    load    = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    rst  = 1'b1;
    load = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy after reset edge", busy, 0);
    @(negedge clk);
    checkOutput("seg in reset", seg, 8'hFF);
    checkOutput("digit_en in reset", digit_en, {DIGITS{1'b1}});
    checkOutput("overflow in reset", overflow, 0);
    repeat (cycles - 1) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_window();
    repeat (WINDOW) @(posedge clk);
  endtask

  // Monitor: each busy fall marks a completed (or aborted) conversion.
  initial begin : monitor
    logic prev_busy;
    int   busy_len;
    exp_t e;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected completion: got busy fall, expected none queued");
        end else begin
          e = sb.pop_front();
          if (!e.aborted) checkOutput("busy length", busy_len, BIN_W);
          while (rst) @(negedge clk);
          checkOutput($sformatf("overflow value %0d", e.value), overflow,
                      (e.value >= pow10(DIGITS)) ? 1 : 0);
          @(negedge clk);
          check_scan(e.value, e.dp);
        end
        busy_len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    apply_reset(3);
    @(negedge clk);
    @(negedge clk);
    check_scan(0, '0);

    applyStimulus(1234, 4'b0000, 0);  wait_window();
    applyStimulus(9999, 4'b0000, 0);  wait_window();
    applyStimulus(10000, 4'b0000, 0); wait_window();
    applyStimulus(0, 4'b1010, 0);     wait_window();

    applyStimulus(42, 4'b0000, 0);
    repeat (4) @(posedge clk);
    #1 num_in = BIN_W'(7);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_window();

    applyStimulus(5, 4'b0100, 0);     wait_window();
    applyStimulus(16383, 4'b0001, 0); wait_window();

    applyStimulus(8888, 4'b0000, 1);
    repeat (4) @(posedge clk);
    apply_reset(2);
    wait_window();

    for (int n = 0; n < 20; n++) begin
      int v;
      v = (n % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      applyStimulus(v, DIGITS'($urandom_range(0, 15)), 0);
      wait_window();
    end

    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
